fifo_serial_tx: RTL

//   Downstream drain stage for the 4-word fifo. When the fifo reports not-empty it issues a
//   one-cycle read request, captures the returned 8-bit word and transmits it LSB-first on a

---
 rtl/fifo_serial_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - fifo drain stage sending each word as an asynchronous serial frame
module fifo_serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              pclk,
    input  logic              clear,
    input  logic              tx_enable,
    input  logic              fifo_nempty,
    input  logic [DATA_W-1:0] fifo_word,
    output logic              fifo_en,
    output logic              fifo_rw,
    output logic              txd,
    output logic              busy,
    output logic              frame_done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt, baud_inc;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              parity, parity_nxt;
    logic              txd_nxt, busy_nxt, fifo_en_nxt, done_nxt;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign baud_inc  = baud_last ? '0 : baud_cnt + BAUD_W'(1);
    assign fifo_rw   = 1'b0;

    always_ff @(posedge pclk) begin
        if (clear) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            fifo_en    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            parity     <= parity_nxt;
            txd        <= txd_nxt;
            busy       <= busy_nxt;
            fifo_en    <= fifo_en_nxt;
            frame_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        baud_nxt   = '0;
        bit_nxt    = bit_cnt;
        shreg_nxt  = shreg;
        parity_nxt = parity;
        case (state)
            IDLE: begin
                bit_nxt = '0;
                if (tx_enable && fifo_nempty) state_nxt = REQ;
            end
            REQ: state_nxt = LOAD;
            LOAD: begin
                state_nxt  = START;
                shreg_nxt  = fifo_word;
                parity_nxt = ^fifo_word;
                bit_nxt    = '0;
            end
            START: begin
                baud_nxt = baud_inc;
                if (baud_last) state_nxt = DATA;
            end
            DATA: begin
                baud_nxt = baud_inc;
                if (baud_last) begin
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                baud_nxt = baud_inc;
                if (baud_last) state_nxt = STOP;
            end
            STOP: begin
                baud_nxt = baud_inc;
                if (baud_last) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        txd_nxt = 1'b1;
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shreg_nxt[0];
            PARITY:  txd_nxt = parity_nxt;
            default: txd_nxt = 1'b1;
        endcase
        busy_nxt    = (state_nxt != IDLE);
        fifo_en_nxt = (state_nxt == REQ);
        done_nxt    = (state_nxt == STOP) && (baud_nxt == BAUD_LAST) && (bit_nxt == STOP_LAST);
    end
endmodule
